// File: rtl/sram_writer.sv
// Posted-write engine for the external 2M x 8 async SRAM: FWFT FIFO plus a timed write-cycle FSM.
// Optional `SRAM_WRITER_AUTOINC_EN adds wr_inc, which pushes data to the previous push address + 1.
module sram_writer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int SETUP_CYC  = 1,
  parameter int WE_CYC     = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  wr,
`ifdef SRAM_WRITER_AUTOINC_EN
  input  logic                  wr_inc,
`endif
  input  logic [28:0]           wdata,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_ovf,
  input  logic                  bus_idle,
  output logic                  own,
  output logic                  busy,
  output logic [20:0]           sram_addr,
  output logic [7:0]            sram_dout,
  output logic                  sram_ce_n,
  output logic                  sram_we_n,
  output logic                  sram_oe_n
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // The shared phase counter counts down to zero, so it is loaded with length-1.
  function automatic logic [3:0] len_m1(input int n);
    return 4'(n - 1);
  endfunction

  logic [28:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  empty;
  logic                  push_req;
  logic                  accept;
  logic                  pop;
  logic [28:0]           push_word;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       own_nxt;
  logic       ce_n_nxt;
  logic       we_n_nxt;

  // Push side: build the word that enters the FIFO
`ifdef SRAM_WRITER_AUTOINC_EN
  logic [20:0] next_addr;
  logic [20:0] push_addr;

  assign push_req  = wr | wr_inc;
  assign push_addr = wr ? wdata[28:8] : next_addr;
  assign push_word = {push_addr, wdata[7:0]};

  always_ff @(posedge clk) begin
    if (!resetq) begin
      next_addr <= '0;
    end else if (accept) begin
      next_addr <= push_addr + 21'd1;
    end
  end
`else
  assign push_req  = wr;
  assign push_word = wdata;
`endif

  assign empty  = (level == '0);
  assign full   = (level == LEVEL_FULL);
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign accept = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= push_word;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!resetq) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push_req && !accept) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Write-cycle FSM: state register and registered pin controls
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state     <= IDLE;
      cnt       <= '0;
      own       <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      own       <= own_nxt;
      sram_ce_n <= ce_n_nxt;
      sram_we_n <= we_n_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    own_nxt   = own;
    ce_n_nxt  = sram_ce_n;
    we_n_nxt  = sram_we_n;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        own_nxt  = 1'b0;
        ce_n_nxt = 1'b1;
        we_n_nxt = 1'b1;
        if (!empty && bus_idle) begin
          pop       = 1'b1;
          own_nxt   = 1'b1;
          ce_n_nxt  = 1'b0;
          state_nxt = SETUP;
          cnt_nxt   = len_m1(SETUP_CYC);
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          we_n_nxt  = 1'b0;
          state_nxt = STROBE;
          cnt_nxt   = len_m1(WE_CYC);
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          we_n_nxt  = 1'b1;
          state_nxt = HOLD;
          cnt_nxt   = len_m1(HOLD_CYC);
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          ce_n_nxt  = 1'b1;
          own_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address/data only move when a new cycle starts, so they stay put through HOLD.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      sram_addr <= '0;
      sram_dout <= '0;
    end else if (pop) begin
      sram_addr <= mem[rptr][28:8];
      sram_dout <= mem[rptr][7:0];
    end
  end

  assign sram_oe_n = 1'b1;
  assign busy      = !empty || (state != IDLE);

endmodule
